// File: rtl/mandelbrot_calc.sv
// rtl/mandelbrot_calc.sv - iterative escape-time engine, one point in flight
// Iterates z <= z^2 + c in signed fixed point and reports the iteration count per pixel.
module mandelbrot_calc #(
    parameter int FPW = 27,
    parameter int AW  = 12,
    parameter int IW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [IW-1:0]         max_iter,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic signed [FPW-1:0] in_x,
    input  logic signed [FPW-1:0] in_y,
    input  logic [AW-1:0]         in_adr,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [IW-1:0]         out_niter,
    output logic [AW-1:0]         out_adr
);

    localparam int F = FPW - 5;
    localparam int P = FPW + 5;
    localparam logic signed [P:0] C_FOUR = (P+1)'(4) <<< F;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_UPD, S_OUT} state_t;

    state_t                r_state;
    state_t                w_next;
    logic signed [FPW-1:0] r_cx;
    logic signed [FPW-1:0] r_cy;
    logic signed [FPW-1:0] r_zx;
    logic signed [FPW-1:0] r_zy;
    logic [AW-1:0]         r_adr;
    logic [IW-1:0]         r_max;
    logic [IW-1:0]         r_niter;
    logic signed [P-1:0]   r_x2;
    logic signed [P-1:0]   r_y2;
    logic signed [P-1:0]   r_xy;
    logic [IW-1:0]         r_out_niter;
    logic [AW-1:0]         r_out_adr;

    logic signed [2*FPW-1:0] w_zx_ext;
    logic signed [2*FPW-1:0] w_zy_ext;
    logic signed [P:0]       w_mag;
    logic                    w_done;

    assign w_zx_ext = (2*FPW)'(r_zx);
    assign w_zy_ext = (2*FPW)'(r_zy);
    // One extra bit so x2+y2 cannot wrap before the escape compare
    assign w_mag    = (P+1)'(r_x2) + (P+1)'(r_y2);
    assign w_done   = (w_mag > C_FOUR) || (r_niter == r_max);

    assign in_rdy    = (r_state == S_IDLE);
    assign out_vld   = (r_state == S_OUT);
    assign out_niter = r_out_niter;
    assign out_adr   = r_out_adr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_vld) w_next = S_MUL;
            S_MUL:   w_next = S_UPD;
            S_UPD:   w_next = w_done ? S_OUT : S_MUL;
            S_OUT:   if (out_rdy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cx        <= '0;
            r_cy        <= '0;
            r_zx        <= '0;
            r_zy        <= '0;
            r_adr       <= '0;
            r_max       <= '0;
            r_niter     <= '0;
            r_x2        <= '0;
            r_y2        <= '0;
            r_xy        <= '0;
            r_out_niter <= '0;
            r_out_adr   <= '0;
        end else if (clk_en) begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (in_vld) begin
                        r_cx    <= in_x;
                        r_cy    <= in_y;
                        r_adr   <= in_adr;
                        r_max   <= max_iter;
                        r_zx    <= '0;
                        r_zy    <= '0;
                        r_niter <= '0;
                    end
                end
                S_MUL: begin
                    // Arithmetic shift of the full product floors toward -inf
                    r_x2 <= P'((w_zx_ext * w_zx_ext) >>> F);
                    r_y2 <= P'((w_zy_ext * w_zy_ext) >>> F);
                    r_xy <= P'((w_zx_ext * w_zy_ext) >>> F);
                end
                S_UPD: begin
                    if (w_done) begin
                        r_out_niter <= r_niter;
                        r_out_adr   <= r_adr;
                    end else begin
                        r_zx    <= FPW'(r_x2 - r_y2 + P'(r_cx));
                        r_zy    <= FPW'((r_xy <<< 1) + P'(r_cy));
                        r_niter <= r_niter + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_calc.sv
// tb/tb_mandelbrot_calc.sv - scoreboard bench for mandelbrot_calc
module tb_mandelbrot_calc;

    localparam int FPW = 27;
    localparam int AW  = 12;
    localparam int IW  = 8;
    localparam int F   = FPW - 5;
    localparam longint ONE = 64'sd1 <<< F;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clk_en = 1'b1;
    logic [IW-1:0]         max_iter = '0;
    logic                  in_vld = 1'b0;
    logic                  in_rdy;
    logic signed [FPW-1:0] in_x = '0;
    logic signed [FPW-1:0] in_y = '0;
    logic [AW-1:0]         in_adr = '0;
    logic                  out_vld;
    logic                  out_rdy = 1'b0;
    logic [IW-1:0]         out_niter;
    logic [AW-1:0]         out_adr;

    mandelbrot_calc #(.FPW(FPW), .AW(AW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .max_iter(max_iter),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_x(in_x), .in_y(in_y), .in_adr(in_adr),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_niter(out_niter), .out_adr(out_adr)
    );

    always #5 clk = ~clk;

    typedef struct packed { int niter; int adr; } exp_t;
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   toggle_en = 1'b0;
    int   tog_cnt = 0;

    initial forever begin
        @(posedge clk);
        #2;
        if (toggle_en) begin
            clk_en = (tog_cnt % 3 == 0);
            tog_cnt++;
        end
    end

    function automatic longint sx(input longint v);
        longint m;
        m = v & ((64'sd1 <<< FPW) - 1);
        if (m[FPW-1]) m = m - (64'sd1 <<< FPW);
        return m;
    endfunction

    function automatic int model(input longint cx, input longint cy, input int mi);
        longint zx = 0, zy = 0, x2, y2, xy;
        int n = 0;
        for (int k = 0; k <= 300; k++) begin
            x2 = (zx * zx) >>> F;
            y2 = (zy * zy) >>> F;
            xy = (zx * zy) >>> F;
            if ((x2 + y2 > 4 * ONE) || (n == mi)) return n;
            zx = sx(x2 - y2 + cx);
            zy = sx(2 * xy + cy);
            n++;
        end
        return n;
    endfunction

    task automatic send(input longint x, input longint y, input int adr, input int mi, output bit ok);
        int g = 0;
        in_x = x[FPW-1:0];
        in_y = y[FPW-1:0];
        in_adr = adr[AW-1:0];
        max_iter = mi[IW-1:0];
        in_vld = 1'b1;
        while (!(in_rdy && clk_en) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        ok = (g < 2000);
        @(negedge clk);
        in_vld = 1'b0;
        if (ok) sb.push_back('{niter: model(x, y, mi), adr: adr});
    endtask

    task automatic get_result(input bit ack, output int niter, output int adr, output int lat, output bit ok);
        int g = 0;
        lat = 0;
        while (!out_vld && g < 5000) begin
            if (clk_en) lat++;
            @(negedge clk);
            g++;
        end
        ok = out_vld;
        niter = int'(out_niter);
        adr = int'(out_adr);
        if (ok && ack) begin
            out_rdy = 1'b1;
            while (!clk_en) @(negedge clk);
            @(negedge clk);
            out_rdy = 1'b0;
        end
    endtask

    task automatic test_reset;
        clk_en = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0 || out_niter !== '0 || out_adr !== '0) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b niter=%0d adr=%0d exp rdy=1 vld=0 niter=0 adr=0",
                     in_rdy, out_vld, out_niter, out_adr);
        end
        rst = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_point(input string name, input longint x, input longint y, input int adr,
                               input int mi, input int exp_lat);
        int n, a, lat;
        bit ok, ok2;
        exp_t e;
        send(x, y, adr, mi, ok);
        get_result(1'b1, n, a, lat, ok2);
        total++;
        if (!ok || !ok2 || sb.size() == 0) begin
            bad++;
            $display("FAIL %s_timeout got accept=%b result=%b exp accept=1 result=1", name, ok, ok2);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++;
            if (n !== e.niter) begin
                bad++;
                $display("FAIL %s_niter got=%0d exp=%0d", name, n, e.niter);
            end
            total++;
            if (a !== e.adr) begin
                bad++;
                $display("FAIL %s_adr got=%0d exp=%0d", name, a, e.adr);
            end
            if (exp_lat >= 0) begin
                total++;
                if (lat !== exp_lat) begin
                    bad++;
                    $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
                end
            end
        end
    endtask

    task automatic test_zero;
        check_point("zero_c", 0, 0, 5, 20, 42);
    endtask

    task automatic test_escape;
        check_point("escape_2p5", 10 * ONE / 4, 0, 12, 255, 4);
        check_point("boundary_m2", -2 * ONE, 0, 13, 255, 512);
        check_point("max_iter_0", ONE / 4, ONE / 4, 14, 0, 2);
    endtask

    task automatic test_backpressure;
        int n, a, lat;
        bit ok, ok2;
        exp_t e;
        send(10 * ONE / 4, 0, 77, 10, ok);
        get_result(1'b0, n, a, lat, ok2);
        total++;
        if (!ok || !ok2 || sb.size() == 0) begin
            bad++;
            $display("FAIL bp_timeout got result=%b exp=1", ok2);
            sb.delete();
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                total++;
                if (out_vld !== 1'b1 || in_rdy !== 1'b0 || int'(out_niter) !== e.niter || int'(out_adr) !== e.adr) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b niter=%0d adr=%0d exp vld=1 rdy=0 niter=%0d adr=%0d",
                             i, out_vld, in_rdy, out_niter, out_adr, e.niter, e.adr);
                end
            end
            out_rdy = 1'b1;
            @(negedge clk);
            out_rdy = 1'b0;
            total++;
            if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
                bad++;
                $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", out_vld, in_rdy);
            end
        end
    endtask

    task automatic test_clk_en;
        toggle_en = 1'b1;
        check_point("clk_en_zero_c", 0, 0, 9, 20, 42);
        toggle_en = 1'b0;
        @(negedge clk);
        clk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n, a, lat;
        bit ok, ok2;
        send(0, 0, 3, 20, ok);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        total++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_niter !== '0 || out_adr !== '0) begin
            bad++;
            $display("FAIL rst_busy got vld=%b rdy=%b niter=%0d adr=%0d exp vld=0 rdy=1 niter=0 adr=0",
                     out_vld, in_rdy, out_niter, out_adr);
        end
        send(10 * ONE / 4, 0, 44, 10, ok);
        get_result(1'b0, n, a, lat, ok2);
        void'(sb.pop_back());
        total++;
        if (!ok2 || n !== 1 || a !== 44) begin
            bad++;
            $display("FAIL rst_pre_out got vld=%b niter=%0d adr=%0d exp vld=1 niter=1 adr=44", ok2, n, a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_niter !== '0 || out_adr !== '0) begin
            bad++;
            $display("FAIL rst_out got vld=%b rdy=%b niter=%0d adr=%0d exp vld=0 rdy=1 niter=0 adr=0",
                     out_vld, in_rdy, out_niter, out_adr);
        end
        check_point("after_rst", ONE / 4, ONE / 2, 6, 50, -1);
    endtask

    task automatic test_chain;
        fork
            begin
                bit ok;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        send(-2 * ONE + c * (3 * ONE / 4), -ONE + r * (2 * ONE / 3), r * 4 + c, 40, ok);
            end
            begin
                int n, a, lat;
                bit ok2;
                exp_t e;
                for (int i = 0; i < 16; i++) begin
                    get_result(1'b1, n, a, lat, ok2);
                    total++;
                    if (!ok2 || sb.size() == 0) begin
                        bad++;
                        $display("FAIL chain_timeout idx=%0d got result=%b exp=1", i, ok2);
                        break;
                    end
                    e = sb.pop_front();
                    total++;
                    if (a !== i || a !== e.adr || n !== e.niter) begin
                        bad++;
                        $display("FAIL chain_result idx=%0d got adr=%0d niter=%0d exp adr=%0d niter=%0d",
                                 i, a, n, e.adr, e.niter);
                    end
                end
            end
        join
        total++;
        if (sb.size() != 0 || out_vld !== 1'b0) begin
            bad++;
            $display("FAIL chain_leftover got queued=%0d vld=%b exp queued=0 vld=0", sb.size(), out_vld);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_escape();
        test_backpressure();
        test_clk_en();
        test_reset_mid();
        test_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
